uart_wb_sequencer: RTL

Wishbone master that configures and feeds the 16550-compatible uart_top over its 8-bit Wishbone slave port. When started, it writes the full register setup: divisor latch, line format, FIFO control and interrupt enable. It then serves a valid/ready byte-transmit stream by polling LSR.THRE and writing THR. It replaces host-driven register traffic when the UART is used standalone.

---
 rtl/uart_wb_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/uart_wb_sequencer.sv
// Wishbone master that programs a 16550 UART (divisor, LCR, FCR, IER) and then feeds THR from a
// valid/ready byte stream by polling LSR.THRE. Optional build macro RX_POLL_EN adds LSR.DR/RBR polling.
`timescale 1ns/1ps
module uart_wb_sequencer #(
    parameter int ADDR_WIDTH  = 3,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  cfg_start,
    input  logic [15:0]           cfg_divisor,
    input  logic [6:0]            cfg_lcr,
    input  logic [7:0]            cfg_fcr,
    input  logic [3:0]            cfg_ier,
    output logic                  cfg_done,
    output logic                  err,
    input  logic                  tx_valid,
    input  logic [7:0]            tx_data,
    output logic                  tx_ready,
`ifdef RX_POLL_EN
    output logic                  rx_valid,
    output logic [7:0]            rx_data,
    input  logic                  rx_ready,
`endif
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [7:0]            wb_dat_o,
    input  logic [7:0]            wb_dat_i,
    output logic                  wb_we_o,
    output logic                  wb_stb_o,
    output logic                  wb_cyc_o,
    output logic [3:0]            wb_sel_o,
    input  logic                  wb_ack_i
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] A_THR = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_IER = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_FCR = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_LCR = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_LSR = ADDR_WIDTH'(5);

    typedef enum logic [3:0] {
        IDLE, W_LCR_DLAB, W_DLL, W_DLM, W_LCR, W_FCR, W_IER,
        READY, R_LSR, W_THR, ERR, R_LSR_RX, R_RBR
    } state_t;

    state_t                state, state_nx;
    logic [15:0]           div_q;
    logic [6:0]            lcr_q;
    logic [7:0]            fcr_q;
    logic [3:0]            ier_q;
    logic [7:0]            tx_q;
    logic [CNT_W-1:0]      cnt;
    logic                  start_ok, acked, expired;
    logic                  acc_go, acc_we;
    logic [ADDR_WIDTH-1:0] acc_adr;
    logic [7:0]            acc_dat;
    logic [6:0]            lcr_src;
    logic                  unused_rd;

    // Only individual status flags of the read data are inspected.
    assign unused_rd = ^wb_dat_i;

    // cfg_start wins over a byte offered in the same cycle, so tx_ready is withheld then.
    assign tx_ready = (state == READY) && !cfg_start;

    always_comb begin
        start_ok = cfg_start && (state == IDLE || state == READY || state == ERR);
        acked    = wb_cyc_o && wb_ack_i;
        expired  = wb_cyc_o && !wb_ack_i && (cnt == CNT_W'(ACK_TIMEOUT - 1));
        state_nx = state;
        if (start_ok) begin
            state_nx = W_LCR_DLAB;
        end else if (expired) begin
            state_nx = ERR;
        end else begin
            case (state)
                W_LCR_DLAB: if (acked) state_nx = W_DLL;
                W_DLL:      if (acked) state_nx = W_DLM;
                W_DLM:      if (acked) state_nx = W_LCR;
                W_LCR:      if (acked) state_nx = W_FCR;
                W_FCR:      if (acked) state_nx = W_IER;
                W_IER:      if (acked) state_nx = READY;
                READY: begin
                    if (tx_valid) state_nx = R_LSR;
`ifdef RX_POLL_EN
                    else if (!rx_valid) state_nx = R_LSR_RX;
`endif
                end
                R_LSR:      if (acked && wb_dat_i[5]) state_nx = W_THR;
                W_THR:      if (acked) state_nx = READY;
`ifdef RX_POLL_EN
                R_LSR_RX:   if (acked) state_nx = wb_dat_i[0] ? R_RBR : READY;
                R_RBR:      if (acked) state_nx = READY;
`endif
                default:    state_nx = state;
            endcase
        end
    end

    // Bus parameters of the access belonging to the state being entered or held.
    always_comb begin
        lcr_src = start_ok ? cfg_lcr : lcr_q;
        acc_go  = 1'b1;
        acc_we  = 1'b1;
        acc_adr = A_THR;
        acc_dat = 8'h00;
        case (state_nx)
            W_LCR_DLAB: begin acc_adr = A_LCR; acc_dat = {1'b1, lcr_src}; end
            W_DLL:      begin acc_adr = A_THR; acc_dat = div_q[7:0]; end
            W_DLM:      begin acc_adr = A_IER; acc_dat = div_q[15:8]; end
            W_LCR:      begin acc_adr = A_LCR; acc_dat = {1'b0, lcr_q}; end
            W_FCR:      begin acc_adr = A_FCR; acc_dat = fcr_q; end
            W_IER:      begin acc_adr = A_IER; acc_dat = {4'b0000, ier_q}; end
            W_THR:      begin acc_adr = A_THR; acc_dat = tx_q; end
            R_LSR:      begin acc_adr = A_LSR; acc_we = 1'b0; end
`ifdef RX_POLL_EN
            R_LSR_RX:   begin acc_adr = A_LSR; acc_we = 1'b0; end
            R_RBR:      begin acc_adr = A_THR; acc_we = 1'b0; end
`endif
            default:    begin acc_go = 1'b0; acc_we = 1'b0; end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= 8'h00;
            wb_sel_o <= 4'b0000;
            cnt      <= '0;
            cfg_done <= 1'b0;
            err      <= 1'b0;
            div_q    <= 16'h0000;
            lcr_q    <= 7'h00;
            fcr_q    <= 8'h00;
            ier_q    <= 4'h0;
            tx_q     <= 8'h00;
        end else begin
            if (start_ok) begin
                div_q    <= cfg_divisor;
                lcr_q    <= cfg_lcr;
                fcr_q    <= cfg_fcr;
                ier_q    <= cfg_ier;
                cfg_done <= 1'b0;
                err      <= 1'b0;
            end
            if (tx_valid && tx_ready) tx_q <= tx_data;
            if (wb_cyc_o) begin
                cnt <= cnt + CNT_W'(1);
                if (acked || expired) begin
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    wb_we_o  <= 1'b0;
                    wb_sel_o <= 4'b0000;
                end
                if (expired) begin
                    err      <= 1'b1;
                    cfg_done <= 1'b0;
                end
                if (acked && state == W_IER) cfg_done <= 1'b1;
            end else if (acc_go) begin
                // Dropping cyc on the ack edge and raising it only from here guarantees an idle cycle.
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_we_o  <= acc_we;
                wb_adr_o <= acc_adr;
                wb_dat_o <= acc_dat;
                wb_sel_o <= 4'b0001;
                cnt      <= '0;
            end
        end
    end

`ifdef RX_POLL_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
        end else if (acked && state == R_RBR) begin
            rx_valid <= 1'b1;
            rx_data  <= wb_dat_i;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end
`endif

endmodule
